// File: rtl/xc_aesmix_pkg.sv
// rtl/xc_aesmix_pkg.sv - shared FSM encoding and GF(2^8) helpers for the AES MixColumns sequencer
package xc_aesmix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] GF_RED = 8'h1b;
    localparam logic [3:0] GF_M2  = 4'h2;
    localparam logic [3:0] GF_M3  = 4'h3;
    localparam logic [3:0] GF_ME  = 4'he;
    localparam logic [3:0] GF_MB  = 4'hb;
    localparam logic [3:0] GF_MD  = 4'hd;
    localparam logic [3:0] GF_M9  = 4'h9;

    function automatic logic [7:0] xtime2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
    endfunction

    // Shift-and-add multiply by a 4-bit constant, enough for every MixColumns coefficient.
    function automatic logic [7:0] xtimeN(input logic [7:0] b, input logic [3:0] n);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = b;
        for (int i = 0; i < 4; i++) begin
            if (n[i]) acc = acc ^ p;
            p = xtime2(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/xc_aesmix_col.sv
// rtl/xc_aesmix_col.sv - combinational MixColumns / InvMixColumns for one 32-bit column
module xc_aesmix_col
    import xc_aesmix_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        enc,
    output logic [31:0] col_out
);

    // x0 is byte j, x1..x3 are bytes j+1..j+3 (mod 4).
    function automatic logic [7:0] mix_byte(input logic [7:0] x0, input logic [7:0] x1,
                                            input logic [7:0] x2, input logic [7:0] x3,
                                            input logic       e);
        if (e)
            return xtimeN(x0, GF_M2) ^ xtimeN(x1, GF_M3) ^ x2 ^ x3;
        else
            return xtimeN(x0, GF_ME) ^ xtimeN(x1, GF_MB) ^ xtimeN(x2, GF_MD) ^ xtimeN(x3, GF_M9);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        a0 = col_in[7:0];
        a1 = col_in[15:8];
        a2 = col_in[23:16];
        a3 = col_in[31:24];
        col_out = {mix_byte(a3, a0, a1, a2, enc),
                   mix_byte(a2, a3, a0, a1, enc),
                   mix_byte(a1, a2, a3, a0, enc),
                   mix_byte(a0, a1, a2, a3, enc)};
    end

endmodule

// File: rtl/xc_aesmix_seq.sv
// rtl/xc_aesmix_seq.sv - column-serial AES MixColumns/InvMixColumns with valid/ready handshakes
module xc_aesmix_seq
    import xc_aesmix_pkg::*;
#(
    parameter logic FAST = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_enc,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    state_t         state;
    logic [1:0]     col;
    logic           phase;
    logic [127:0]   cap_state;
    logic           cap_enc;
    logic [127:0]   result;
    logic [31:0]    op_reg;
    logic           out_valid_r;
    logic [31:0]    col_sel;
    logic [31:0]    mix_in;
    logic [31:0]    mix_out;

    always_comb begin
        col_sel = cap_state[{col, 5'd0} +: 32];
        mix_in  = FAST ? col_sel : op_reg;
    end

    xc_aesmix_col u_col (
        .col_in  (mix_in),
        .enc     (cap_enc),
        .col_out (mix_out)
    );

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state       <= ST_IDLE;
            col         <= 2'd0;
            phase       <= 1'b0;
            cap_state   <= '0;
            cap_enc     <= 1'b0;
            result      <= '0;
            op_reg      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cap_state <= in_state;
                        cap_enc   <= in_enc;
                        result    <= '0;
                        col       <= 2'd0;
                        phase     <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The slow build spends phase 0 registering the operand to shorten the path.
                    if (FAST || phase) begin
                        result[{col, 5'd0} +: 32] <= mix_out;
                        col   <= col + 2'd1;
                        phase <= 1'b0;
                        if (col == 2'd3) begin
                            state       <= ST_DONE;
                            out_valid_r <= 1'b1;
                        end
                    end else begin
                        op_reg <= col_sel;
                        phase  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        result      <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = out_valid_r;
    assign out_state = out_valid_r ? result : '0;

endmodule

// File: tb/tb_xc_aesmix_seq.sv
// tb/tb_xc_aesmix_seq.sv - scoreboard bench for xc_aesmix_seq, FAST=1 and FAST=0 instances
module tb_xc_aesmix_seq;

    localparam logic [127:0] ENC_IN  = 128'hc6c6c6c6_01010101_5c220af2_455313db;
    localparam logic [127:0] ENC_OUT = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
    localparam logic [127:0] DEC_IN  = {4{32'hd6d7d5d5}};
    localparam logic [127:0] DEC_OUT = {4{32'hd5d4d4d4}};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset;
    logic         f_flush, f_in_valid, f_in_ready, f_in_enc, f_out_valid, f_out_ready, f_busy;
    logic [127:0] f_in_state, f_out_state;
    logic         s_flush, s_in_valid, s_in_ready, s_in_enc, s_out_valid, s_out_ready, s_busy;
    logic [127:0] s_in_state, s_out_state;

    xc_aesmix_seq #(.FAST(1'b1)) dut_f (
        .clock(clock), .reset(reset), .flush(f_flush),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_enc(f_in_enc), .in_state(f_in_state),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_state(f_out_state), .busy(f_busy)
    );

    xc_aesmix_seq #(.FAST(1'b0)) dut_s (
        .clock(clock), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_enc(s_in_enc), .in_state(s_in_state),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_state(s_out_state), .busy(s_busy)
    );

    typedef struct {
        logic [127:0] exp;
        int           acc;
        int           lat;
    } exp_t;

    exp_t q_f[$];
    exp_t q_s[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    logic f_prev     = 1'b0;
    logic s_prev     = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: event occurred, required none (cycle %0d)", name, cyc);
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Monitors: latency on first valid cycle, data on handshake, zero output otherwise.
    always @(negedge clock) begin
        if (cyc > 0) begin
            if (f_out_valid && !f_prev) begin
                if (q_f.size() == 0) fail("f_unexpected_valid");
                else chk_int("f_latency", cyc - q_f[0].acc, q_f[0].lat);
            end
            if (!f_out_valid) chk128("f_out_zero", f_out_state, '0);
            if (f_out_valid && f_out_ready) begin
                if (q_f.size() == 0) fail("f_unexpected_handshake");
                else begin
                    chk128("f_result", f_out_state, q_f[0].exp);
                    void'(q_f.pop_front());
                end
            end
        end
        f_prev <= f_out_valid;
    end

    always @(negedge clock) begin
        if (cyc > 0) begin
            if (s_out_valid && !s_prev) begin
                if (q_s.size() == 0) fail("s_unexpected_valid");
                else chk_int("s_latency", cyc - q_s[0].acc, q_s[0].lat);
            end
            if (!s_out_valid) chk128("s_out_zero", s_out_state, '0);
            if (s_out_valid && s_out_ready) begin
                if (q_s.size() == 0) fail("s_unexpected_handshake");
                else begin
                    chk128("s_result", s_out_state, q_s[0].exp);
                    void'(q_s.pop_front());
                end
            end
        end
        s_prev <= s_out_valid;
    end

    // Returns just after the acceptance edge; in_enc is then flipped to show it is not re-sampled.
    task automatic send(input int w, input logic enc, input logic [127:0] st, input logic [127:0] exp);
        exp_t e;
        int   n;
        bit   done;
        n    = 0;
        done = 0;
        @(posedge clock); #1;
        if (w == 0) begin f_in_valid = 1'b1; f_in_enc = enc; f_in_state = st; end
        else        begin s_in_valid = 1'b1; s_in_enc = enc; s_in_state = st; end
        while (!done && n < 100) begin
            @(negedge clock);
            if ((w == 0) ? f_in_ready : s_in_ready) begin
                e.exp = exp;
                e.acc = cyc + 1;
                e.lat = (w == 0) ? 4 : 8;
                if (w == 0) q_f.push_back(e); else q_s.push_back(e);
                done = 1;
            end else n++;
        end
        if (!done) fail("send_timeout");
        @(posedge clock); #1;
        if (w == 0) begin f_in_valid = 1'b0; f_in_enc = ~enc; f_in_state = '1; end
        else        begin s_in_valid = 1'b0; s_in_enc = ~enc; s_in_state = '1; end
    endtask

    task automatic drain(input int w);
        int n;
        n = 0;
        while (((w == 0) ? q_f.size() : q_s.size()) != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        if (n >= 100) fail("drain_timeout");
        #1;
    endtask

    task automatic wait_f_valid();
        int n;
        n = 0;
        while (!f_out_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!f_out_valid) fail("f_valid_timeout");
    endtask

    initial begin
        reset = 1'b1;
        f_flush = 1'b0; f_in_valid = 1'b0; f_in_enc = 1'b0; f_in_state = '0; f_out_ready = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_enc = 1'b0; s_in_state = '0; s_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk1("rst_f_in_ready", f_in_ready, 1'b1);
        chk1("rst_f_out_valid", f_out_valid, 1'b0);
        chk128("rst_f_out_state", f_out_state, '0);
        chk1("rst_f_busy", f_busy, 1'b0);
        chk1("rst_s_in_ready", s_in_ready, 1'b1);
        chk1("rst_s_busy", s_busy, 1'b0);
        reset = 1'b0;

        send(0, 1'b1, ENC_IN, ENC_OUT);   drain(0);
        send(0, 1'b0, ENC_OUT, ENC_IN);   drain(0);
        send(0, 1'b0, DEC_IN, DEC_OUT);   drain(0);

        send(1, 1'b1, ENC_IN, ENC_OUT);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk1("s_in_ready_run", s_in_ready, 1'b0);
        end
        drain(1);
        send(1, 1'b0, ENC_OUT, ENC_IN);   drain(1);

        // Back-pressure: result must hold while out_ready is low.
        f_out_ready = 1'b0;
        send(0, 1'b1, ENC_IN, ENC_OUT);
        wait_f_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk128("hold_out_state", f_out_state, ENC_OUT);
            chk1("hold_in_ready", f_in_ready, 1'b0);
            chk1("hold_busy", f_busy, 1'b1);
        end
        @(posedge clock); #1;
        f_out_ready = 1'b1;
        @(negedge clock);
        chk1("handshake_in_ready", f_in_ready, 1'b0);
        @(posedge clock); #1;
        chk1("post_handshake_in_ready", f_in_ready, 1'b1);
        chk1("post_handshake_busy", f_busy, 1'b0);

        // Flush while column 2 is being processed.
        send(0, 1'b1, ENC_IN, ENC_OUT);
        @(posedge clock);
        @(posedge clock); #1;
        f_flush = 1'b1;
        @(posedge clock); #1;
        chk1("flush_in_ready", f_in_ready, 1'b1);
        chk1("flush_out_valid", f_out_valid, 1'b0);
        chk128("flush_out_state", f_out_state, '0);
        chk1("flush_busy", f_busy, 1'b0);
        f_flush = 1'b0;
        q_f.delete();
        send(0, 1'b0, ENC_OUT, ENC_IN);   drain(0);

        // Flush coincident with a request in IDLE must not accept it.
        @(posedge clock); #1;
        f_in_valid = 1'b1; f_in_enc = 1'b1; f_in_state = ENC_IN; f_flush = 1'b1;
        @(posedge clock); #1;
        chk1("flush_idle_busy", f_busy, 1'b0);
        f_in_valid = 1'b0; f_flush = 1'b0;

        // Reset while holding a result in DONE.
        f_out_ready = 1'b0;
        send(0, 1'b1, ENC_IN, ENC_OUT);
        wait_f_valid();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk1("rst_done_out_valid", f_out_valid, 1'b0);
        chk128("rst_done_out_state", f_out_state, '0);
        chk1("rst_done_in_ready", f_in_ready, 1'b1);
        chk1("rst_done_busy", f_busy, 1'b0);
        reset = 1'b0;
        q_f.delete();
        f_out_ready = 1'b1;
        send(0, 1'b1, DEC_OUT, DEC_IN);   drain(0);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/xc_aesmix_seq.md
XC_AESMIX_SEQ -- requirements
Module: xc_aesmix_seq

Interface
REQ-001 SHALL have parameter FAST, default 1'b1: 1'b1 processes one column per cycle; 1'b0 processes one column per two cycles (operand register stage, then compute).
REQ-002 SHALL have port clock, input, 1 bit: clock.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port flush, input, 1 bit: abort the current operation and return to IDLE.
REQ-005 SHALL have port in_valid, input, 1 bit: request present.
REQ-006 SHALL have port in_ready, output, 1 bit: request accepted this cycle when both in_valid and in_ready are high.
REQ-007 SHALL have port in_enc, input, 1 bit: 1 selects MixColumns, 0 selects InvMixColumns.
REQ-008 SHALL have port in_state, input, 128 bits: AES state. Column i is [32i+31:32i]; byte j of a column is bits [8j+7:8j].
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: result consumed when both out_valid and out_ready are high.
REQ-011 SHALL have port out_state, output, 128 bits: transformed state, using the same layout as in_state.
REQ-012 SHALL have port busy, output, 1 bit: high in the RUN and DONE states.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1. On in_valid, the block SHALL capture in_state and in_enc, clear the result register, set col=0 and phase=0, and go to RUN.
REQ-015 In RUN, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-016 In RUN with FAST=1, each cycle SHALL write column col of the result, then increment col. After col 3 is written, the FSM SHALL go to DONE.
REQ-017 In RUN with FAST=0, phase 0 SHALL register captured column col. Phase 1 SHALL compute from that register, write result column col, and increment col.
REQ-018 Latency SHALL be measured from the acceptance edge to the first cycle with out_valid high: 4 cycles for FAST=1 and 8 cycles for FAST=0.
REQ-019 For encrypt, output byte j SHALL be 2*a[j] ^ 3*a[j+1] ^ a[j+2] ^ a[j+3]. Indices are mod 4.
REQ-020 For decrypt, output byte j SHALL be 0e*a[j] ^ 0b*a[j+1] ^ 0d*a[j+2] ^ 09*a[j+3]. Indices are mod 4.
REQ-021 All products SHALL be computed in GF(2^8) with the reduction polynomial 0x11b.
REQ-022 In DONE, out_valid SHALL be 1 and out_state SHALL hold stable until the handshake. On out_ready, the FSM SHALL go to IDLE.
REQ-023 The block SHALL NOT accept a new request in the same cycle as the output handshake; in_ready first rises in the following cycle.
REQ-024 out_state SHALL be all-zero whenever out_valid is 0. No partial result shall be visible.
REQ-025 flush SHALL take priority over every other event in any state. Next cycle: IDLE, col=0, phase=0, captured state and result zeroed, out_valid=0.
REQ-026 flush in IDLE coincident with in_valid SHALL NOT accept the request.
REQ-027 out_ready while not in DONE SHALL have no effect.
REQ-028 in_enc changes after acceptance SHALL have no effect; the captured value governs the whole operation.

Reset
REQ-029 Reset SHALL force state IDLE, col=0, phase=0, and all data registers to zero.
REQ-030 During and after reset: in_ready=1, out_valid=0, out_state=0, busy=0.
REQ-031 Reset mid-RUN or in DONE SHALL discard the operation without raising out_valid.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the GF constants 8'h1b, 4'he, 4'hb, 4'hd and 4'h9, and the xtime2 and xtimeN functions.
REQ-033 A combinational sub-module xc_aesmix_col SHALL transform one 32-bit column: inputs col_in and enc, output col_out.
REQ-034 xc_aesmix_seq SHALL instantiate exactly one xc_aesmix_col.

Verification
REQ-035 Encrypt, FAST=1: columns db,13,53,45 | f2,0a,22,5c | 01,01,01,01 | c6,c6,c6,c6 -> 8e,4d,a1,bc | 9f,dc,58,9d | 01,01,01,01 | c6,c6,c6,c6, with out_valid exactly 4 cycles after acceptance.
REQ-036 Decrypt of the REQ-035 output SHALL return the REQ-035 input. Column d5,d5,d7,d6 SHALL decrypt to d4,d4,d4,d5.
REQ-037 FAST=0 with the REQ-035 stimulus SHALL give the same result with an 8-cycle latency, and in_ready=0 throughout.
REQ-038 With out_ready held low for 10 cycles, out_state SHALL stay stable, in_ready=0 and busy=1. After the handshake, in_ready=1 on the next cycle.
REQ-039 Flush asserted at RUN col=2 -> next cycle IDLE, out_valid=0, out_state=0. A following request SHALL produce a correct result.
REQ-040 Reset asserted in DONE -> out_valid=0 next cycle and no stale data on out_state.
